// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encodings, owner codes and read-latency limits for mem_port_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_PER = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational 2-way grant between CPU and peripheral.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the CPU wins ties.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req_i,
    input  logic per_req_i,
    input  logic last_grant_i,
    output logic grant_o
);

    logic tie_pick;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie_pick = ~last_grant_i;
`else
    assign tie_pick = OWNER_CPU;
`endif

    // With no request the previous grantee is kept so owner never glitches.
    assign grant_o = cpu_req_i ? (per_req_i ? tie_pick : OWNER_CPU)
                               : (per_req_i ? OWNER_PER : last_grant_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the CPU and a peripheral master.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin ties; default is fixed CPU priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    output logic [DATA_W-1:0] per_rdata,
    output logic              per_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);

    localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam int CNT_W = $clog2(LAT) + 1;

    arb_state_e        state_q;
    logic              owner_q;
    logic              we_q;
    logic              mem_we_q;
    logic              cpu_ack_q;
    logic              per_ack_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] per_rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              grant_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    arb_pick u_pick (
        .cpu_req_i    (cpu_req),
        .per_req_i    (per_req),
        .last_grant_i (owner_q),
        .grant_o      (grant_d)
    );

    assign we_d    = (grant_d == OWNER_PER) ? per_we    : cpu_we;
    assign addr_d  = (grant_d == OWNER_PER) ? per_addr  : cpu_addr;
    assign wdata_d = (grant_d == OWNER_PER) ? per_wdata : cpu_wdata;

    // Reads always spend LAT cycles in RDWAIT so the RAM output has settled before capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_PER;
            we_q        <= 1'b0;
            mem_we_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            per_ack_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            per_rdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_req || per_req) begin
                        owner_q     <= grant_d;
                        we_q        <= we_d;
                        mem_we_q    <= we_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we_q <= 1'b0;
                    if (we_q) begin
                        cpu_ack_q <= (owner_q == OWNER_CPU);
                        per_ack_q <= (owner_q == OWNER_PER);
                        state_q   <= DONE;
                    end else begin
                        cnt_q   <= CNT_W'(LAT - 1);
                        state_q <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (cnt_q == '0) begin
                        if (owner_q == OWNER_CPU) cpu_rdata_q <= mem_rdata;
                        else                      per_rdata_q <= mem_rdata;
                        cpu_ack_q <= (owner_q == OWNER_CPU);
                        per_ack_q <= (owner_q == OWNER_PER);
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    cpu_ack_q <= 1'b0;
                    per_ack_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign per_rdata = per_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign per_ack   = per_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign owner     = owner_q;

endmodule
